cache_block_fetch: RTL and testbench
====================================

Name: cache_block_fetch

Overview:
- Upstream sequencer for the AXI4-Lite read master. Fills one cache block by issuing consecutive single-word reads through the master's start/addr/done interface.
- Assembles the returned words into a block-wide register and returns it to the cache controller with a done pulse and a fault flag.
- Sits between the cache FSM (refill request) and the AXI4-Lite read master.

Parameters:
- AXI_ADDR_WIDTH, 64, address width; matches the read master.
- AXI_DATA_WIDTH, 32, word width per AXI read; matches the read master.
- BLOCK_WIDTH, 512, cache block width in bits; must be an integer multiple of AXI_DATA_WIDTH. Derived values: N_WORDS = BLOCK_WIDTH/AXI_DATA_WIDTH (16 by default), BYTES = AXI_DATA_WIDTH/8.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- arst  in  1  reset, synchronous, active-high.
- i_start_fetch  in  1  request pulse from the cache FSM; sampled only in IDLE.
- i_addr  in  AXI_ADDR_WIDTH  any address inside the target block.
- o_block  out  BLOCK_WIDTH  assembled block; word k is at [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
- o_done  out  1  one-cycle pulse; the fetch has finished.
- o_access_fault  out  1  valid while o_done=1; a word returned a fault.
- o_busy  out  1  high in every state except IDLE.
- o_read_addr  out  AXI_ADDR_WIDTH  word address to the read master (its i_addr).
- o_start_read  out  1  one-cycle start pulse to the read master (its i_start_read).
- i_read_data  in  AXI_DATA_WIDTH  read master o_data.
- i_read_done  in  1  read master o_done.
- i_access_fault  in  1  read master o_access_fault; sampled only when i_read_done=1.

Behaviour:
- Reset (arst=1 at a clk edge):
  - State goes to IDLE and the counter clears.
  - o_block=0, o_read_addr=0, o_start_read=0, o_done=0, o_access_fault=0, o_busy=0.
  - Reset mid-fetch abandons the fetch with no o_done pulse. The read master is reset by the same signal.
- Registers:
  - base address, with the low log2(BLOCK_WIDTH/8) bits forced to 0;
  - word counter, log2(N_WORDS) bits;
  - fault flag;
  - o_block.
- State IDLE:
  - On i_start_fetch=1: latch the aligned base, clear the counter and fault flag, go to ISSUE.
  - o_block holds its previous value.
- State ISSUE (exactly 1 cycle):
  - o_start_read=1, o_read_addr = base + count*BYTES, then go to WAIT.
- State WAIT:
  - o_read_addr holds stable and o_start_read=0.
  - On i_read_done=1: write i_read_data into word[count] of o_block.
  - If i_access_fault=1: set the fault flag and go to DONE (abort; remaining words are not read and keep their old values).
  - Else if count==N_WORDS-1: go to DONE.
  - Else: count+1, go to ISSUE.
- State DONE (exactly 1 cycle):
  - o_done=1, o_access_fault=fault flag, then go to IDLE.
  - o_block is final and stable from this cycle until the next accepted request.
- Timing:
  - o_done rises in the cycle after the final i_read_done.
  - The next ISSUE follows a non-final i_read_done by exactly 1 cycle.
  - Total fetch time = 1 (IDLE accept) + sum over words of (1 + master latency) + 1.
- i_start_fetch while o_busy=1 is ignored; no queuing.
- i_start_fetch in the DONE cycle is ignored. A request in the first IDLE cycle after DONE is accepted.
- i_read_done in IDLE, ISSUE or DONE is ignored.
- Address arithmetic is modulo 2^AXI_ADDR_WIDTH. It cannot wrap inside a block because the base is aligned.

Test Plan:
- Reset check: after arst, all outputs are 0 and o_busy=0; drive i_read_done=1 in IDLE -> no state change.
- Normal fill with defaults: i_addr=0x1000_0024 -> o_read_addr sequence 0x1000_0000, 0x1000_0004, …, 0x1000_003C (16 start pulses). Return data 0xA0+k -> o_block word k = 0xA0+k, one o_done pulse, o_access_fault=0.
- Fault abort: i_access_fault=1 on word 5 -> exactly 6 start pulses. o_done with o_access_fault=1; words 0-5 updated, words 6-15 retain prior values.
- Busy rejection: pulse i_start_fetch with i_addr=0x2000_0000 during WAIT of a fetch to 0x1000_0000 -> no effect; only 0x1000_xxxx addresses are issued.
- Back-to-back: i_start_fetch held high through DONE -> the second fetch is accepted in the first IDLE cycle after DONE; the DONE cycle never starts a fetch.
- Reset mid-fetch: arst during word 7 WAIT -> IDLE next cycle, o_block=0, no o_done. A new fetch then completes normally with the master in lockstep.

Source files
------------

// File: rtl/cache_block_fetch.sv
// Cache block refill sequencer: fills one BLOCK_WIDTH-bit cache block by issuing
// consecutive single-word reads to the AXI4-Lite read master, assembles the
// returned words, and reports completion with a one-cycle done pulse and a fault
// flag. A faulting word aborts the fill; words not yet read keep their old value.
module cache_block_fetch #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BLOCK_WIDTH    = 512
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      i_start_fetch,
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  output logic [BLOCK_WIDTH-1:0]    o_block,
  output logic                      o_done,
  output logic                      o_access_fault,
  output logic                      o_busy,
  output logic [AXI_ADDR_WIDTH-1:0] o_read_addr,
  output logic                      o_start_read,
  input  logic [AXI_DATA_WIDTH-1:0] i_read_data,
  input  logic                      i_read_done,
  input  logic                      i_access_fault
);

  localparam int N_WORDS = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int BYTES   = AXI_DATA_WIDTH / 8;
  localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int OFF_W   = $clog2(BLOCK_WIDTH / 8);

  // Clears the byte-offset-within-block bits so every fill starts at word 0.
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((AXI_ADDR_WIDTH'(1) << OFF_W) - AXI_ADDR_WIDTH'(1));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   base_q, base_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        fault_q, fault_d;
  logic [BLOCK_WIDTH-1:0]      block_q, block_d;
  logic [AXI_ADDR_WIDTH-1:0]   raddr_q, raddr_d;

  // Byte address of word 'cnt' inside the block starting at 'base' (modulo 2^AXI_ADDR_WIDTH).
  function automatic logic [AXI_ADDR_WIDTH-1:0] word_addr(
    input logic [AXI_ADDR_WIDTH-1:0] base,
    input logic [CNT_W-1:0]          cnt
  );
    return base + (AXI_ADDR_WIDTH'(cnt) * AXI_ADDR_WIDTH'(BYTES));
  endfunction

  // State, datapath and output-address registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      block_q <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      block_q <= block_d;
      raddr_q <= raddr_d;
    end
  end

  // Next-state logic; the read address is computed one cycle ahead so it is
  // already registered when ISSUE presents it to the read master.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    block_d = block_q;
    raddr_d = raddr_q;
    case (state_q)
      S_IDLE: begin
        if (i_start_fetch) begin
          base_d  = i_addr & ALIGN_MASK;
          raddr_d = i_addr & ALIGN_MASK;
          cnt_d   = '0;
          fault_d = 1'b0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_read_done) begin
          for (int k = 0; k < N_WORDS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              block_d[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = i_read_data;
            end else begin
              block_d[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] =
                block_q[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
          end
          if (i_access_fault) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            raddr_d = word_addr(base_q, cnt_q + CNT_W'(1));
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decode straight from the registered state, so they are glitch-free.
  assign o_block        = block_q;
  assign o_read_addr    = raddr_q;
  assign o_start_read   = (state_q == S_ISSUE);
  assign o_done         = (state_q == S_DONE);
  assign o_access_fault = (state_q == S_DONE) && fault_q;
  assign o_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_block_fetch.sv
// Directed bench for cache_block_fetch: a small read-master responder model with
// programmable latency and fault injection, a table of fill scenarios, and
// hand-written sequences for busy rejection, back-to-back and mid-fetch reset.
module tb_cache_block_fetch;

  logic         clk = 1'b0;
  logic         arst;
  logic         i_start_fetch;
  logic [63:0]  i_addr;
  logic [511:0] o_block;
  logic         o_done;
  logic         o_access_fault;
  logic         o_busy;
  logic [63:0]  o_read_addr;
  logic         o_start_read;
  logic [31:0]  i_read_data;
  logic         i_read_done;
  logic         i_access_fault;

  cache_block_fetch dut (
    .clk            (clk),
    .arst           (arst),
    .i_start_fetch  (i_start_fetch),
    .i_addr         (i_addr),
    .o_block        (o_block),
    .o_done         (o_done),
    .o_access_fault (o_access_fault),
    .o_busy         (o_busy),
    .o_read_addr    (o_read_addr),
    .o_start_read   (o_start_read),
    .i_read_data    (i_read_data),
    .i_read_done    (i_read_done),
    .i_access_fault (i_access_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          lat;
    int          fault_word;
    logic [31:0] dbase;
    logic [63:0] exp_base;
    int          exp_starts;
    logic        exp_fault;
  } vec_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          lat = 1;
  int          fault_word = -1;
  logic [31:0] dbase = 32'h0;
  int          start_cnt = 0;
  logic [63:0] addr_q[$];
  logic        stray = 1'b0;
  logic [31:0] exp_w [16];
  vec_t        vecs [5];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [511:0] exp_block();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[k*32 +: 32] = exp_w[k];
    return b;
  endfunction

  // Read-master model: answers each start pulse after 'lat' WAIT cycles.
  initial begin
    int pend;
    int cnt;
    int widx;
    pend = 0; cnt = 0; widx = 0;
    i_read_done = 1'b0; i_access_fault = 1'b0; i_read_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      i_read_done = stray;
      i_access_fault = 1'b0;
      if (arst) begin
        pend = 0;
      end else if (pend != 0) begin
        if (cnt == 0) begin
          i_read_done    = 1'b1;
          i_read_data    = dbase + 32'(widx);
          i_access_fault = (fault_word >= 0) && (widx == fault_word);
          pend = 0;
        end else begin
          cnt--;
        end
      end
      if (o_start_read && !arst) begin
        start_cnt++;
        addr_q.push_back(o_read_addr);
        widx = int'(o_read_addr[5:2]);
        pend = 1;
        cnt  = lat - 1;
      end
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!o_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    lat = v.lat; fault_word = v.fault_word; dbase = v.dbase;
    start_cnt = 0; addr_q.delete();
    @(negedge clk);
    i_addr = v.addr; i_start_fetch = 1'b1;
    @(negedge clk);
    i_start_fetch = 1'b0;
    wait_done(cyc);
    chk({tag, "_done"}, o_done, 1'b1);
    chk({tag, "_fault"}, o_access_fault, v.exp_fault);
    chk({tag, "_starts"}, start_cnt, v.exp_starts);
    chk({tag, "_cycles"}, cyc, v.exp_starts * (1 + v.lat) + 1);
    for (int k = 0; k < addr_q.size(); k++)
      chk({tag, "_addr"}, addr_q[k], v.exp_base + 64'(4 * k));
    for (int k = 0; k < v.exp_starts; k++) exp_w[k] = v.dbase + 32'(k);
    chk({tag, "_block"}, o_block, exp_block());
    @(negedge clk);
    chk({tag, "_done_pulse"}, o_done, 1'b0);
    chk({tag, "_idle"}, o_busy, 1'b0);
    chk({tag, "_block_hold"}, o_block, exp_block());
  endtask

  initial begin
    int cyc;
    int bad;
    int dcount;
    vec_t v;
    vecs[0] = '{64'h0000_0000_1000_0024, 1, -1, 32'h0000_00A0, 64'h0000_0000_1000_0000, 16, 1'b0};
    vecs[1] = '{64'h0000_0000_2000_007F, 3,  5, 32'h0000_0B00, 64'h0000_0000_2000_0040,  6, 1'b1};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFC1, 2,  0, 32'h0000_0C00, 64'hFFFF_FFFF_FFFF_FFC0,  1, 1'b1};
    vecs[3] = '{64'h0000_0000_0000_0040, 1, 15, 32'h0000_0D00, 64'h0000_0000_0000_0040, 16, 1'b1};
    vecs[4] = '{64'h0000_0000_3000_0000, 4, -1, 32'h0000_0E00, 64'h0000_0000_3000_0000, 16, 1'b0};
    for (int k = 0; k < 16; k++) exp_w[k] = 32'h0;

    // Reset state
    arst = 1'b1; i_start_fetch = 1'b0; i_addr = 64'h0;
    repeat (3) @(negedge clk);
    chk("rst_block", o_block, 512'h0);
    chk("rst_raddr", o_read_addr, 64'h0);
    chk("rst_start", o_start_read, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_fault", o_access_fault, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    arst = 1'b0;

    // Stray read-done in IDLE is ignored
    stray = 1'b1;
    repeat (3) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    chk("stray_busy", o_busy, 1'b0);
    chk("stray_done", o_done, 1'b0);
    chk("stray_block", o_block, 512'h0);

    // Table of fills (words 6-15 of vec 1 retain vec 0 data)
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Busy rejection: second request during WAIT must be dropped
    lat = 2; fault_word = -1; dbase = 32'h0000_0100;
    start_cnt = 0; addr_q.delete();
    @(negedge clk);
    i_addr = 64'h0000_0000_1000_0000; i_start_fetch = 1'b1;
    @(negedge clk);
    i_start_fetch = 1'b0;
    @(negedge clk);
    chk("busy_in_wait", {o_busy, o_start_read}, 2'b10);
    i_addr = 64'h0000_0000_2000_0000; i_start_fetch = 1'b1;
    @(negedge clk);
    i_start_fetch = 1'b0;
    wait_done(cyc);
    chk("busy_done", o_done, 1'b1);
    chk("busy_starts", start_cnt, 16);
    bad = 0;
    foreach (addr_q[k]) if (addr_q[k][63:16] != 48'h0000_0000_1000) bad++;
    chk("busy_addr_region", bad, 0);
    for (int k = 0; k < 16; k++) exp_w[k] = 32'h0000_0100 + 32'(k);
    chk("busy_block", o_block, exp_block());
    repeat (3) @(negedge clk);
    chk("busy_no_queue", {o_busy, 32'(start_cnt)}, {1'b0, 32'd16});

    // Back-to-back: request held high through DONE
    lat = 1; dbase = 32'h0000_0500;
    start_cnt = 0; addr_q.delete();
    @(negedge clk);
    i_addr = 64'h0000_0000_5000_0010; i_start_fetch = 1'b1;
    @(negedge clk);
    wait_done(cyc);
    chk("b2b_first_done", o_done, 1'b1);
    chk("b2b_first_starts", start_cnt, 16);
    @(negedge clk);
    chk("b2b_idle_after_done", {o_busy, o_start_read}, 2'b00);
    @(negedge clk);
    chk("b2b_second_issue", o_start_read, 1'b1);
    chk("b2b_second_addr", o_read_addr, 64'h0000_0000_5000_0000);
    i_start_fetch = 1'b0;
    @(negedge clk);
    wait_done(cyc);
    chk("b2b_second_done", o_done, 1'b1);
    chk("b2b_total_starts", start_cnt, 32);
    for (int k = 0; k < 16; k++) exp_w[k] = 32'h0000_0500 + 32'(k);
    chk("b2b_block", o_block, exp_block());
    @(negedge clk);

    // Reset during word 7 WAIT
    lat = 3; dbase = 32'h0000_0600;
    start_cnt = 0; addr_q.delete();
    @(negedge clk);
    i_addr = 64'h0000_0000_6000_0000; i_start_fetch = 1'b1;
    @(negedge clk);
    i_start_fetch = 1'b0;
    cyc = 0;
    while (!(start_cnt == 8 && o_busy && !o_start_read) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reach_word7", {32'(start_cnt), o_busy, o_start_read}, {32'd8, 1'b1, 1'b0});
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    chk("mid_busy", o_busy, 1'b0);
    chk("mid_block", o_block, 512'h0);
    chk("mid_raddr", o_read_addr, 64'h0);
    dcount = 0;
    repeat (6) begin
      if (o_done) dcount++;
      @(negedge clk);
    end
    chk("mid_no_done", dcount, 0);
    chk("mid_no_more_issue", start_cnt, 8);
    for (int k = 0; k < 16; k++) exp_w[k] = 32'h0;
    v = '{64'h0000_0000_7000_0008, 2, -1, 32'h0000_0700, 64'h0000_0000_7000_0000, 16, 1'b0};
    run_vec(v, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
